// File: rtl/uart_link_pkg.sv
// Shared defaults and TX state encoding for the UART link controller.
package uart_link_pkg;
  localparam int DEFAULT_HEADER_BYTES = 80;
  localparam int DEFAULT_NONCE_BYTES  = 4;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_SEND      = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the pointer; the pointer
// moves just past the granted requester whenever a grant is accepted.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] grant
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] grant_idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(ptr_reg) + k) % N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (accept && found) begin
      ptr_reg <= (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/uart_link_ctrl.sv
// UART link controller: assembles received bytes into block headers and
// streams arbitrated hashing-core nonces back out, MSB first.
module uart_link_ctrl
  import uart_link_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int HEADER_BYTES = DEFAULT_HEADER_BYTES,
  parameter int NONCE_BYTES  = DEFAULT_NONCE_BYTES
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_rdy,
  output logic                      rx_rdy_clr,
  output logic [7:0]                tx_data,
  output logic                      tx_wr_en,
  input  logic                      tx_busy,
  input  logic [N_REQ-1:0]          nonce_req,
  input  logic [N_REQ*32-1:0]       nonce_in,
  output logic [N_REQ-1:0]          nonce_ack,
  output logic [HEADER_BYTES*8-1:0] header_data,
  output logic                      header_valid,
  output logic [31:0]               byte_count
);
  localparam int IW = $clog2(HEADER_BYTES);
  localparam int CW = $clog2(NONCE_BYTES + 1);

  // ---------------- RX path ----------------
  logic [HEADER_BYTES*8-1:0] staging_reg;
  logic [IW-1:0]             index_reg;
  logic                      rx_armed_reg;
  logic                      rx_capture;

  // The ready flag must be seen low once before the next byte is taken, so a
  // flag that lingers after the clear pulse is not read twice.
  assign rx_capture = rx_rdy && !rx_rdy_clr && rx_armed_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      staging_reg  <= '0;
      index_reg    <= '0;
      rx_armed_reg <= 1'b1;
      rx_rdy_clr   <= 1'b0;
      header_data  <= '0;
      header_valid <= 1'b0;
      byte_count   <= '0;
    end else begin
      rx_rdy_clr   <= rx_capture;
      header_valid <= 1'b0;
      if (!rx_rdy) rx_armed_reg <= 1'b1;
      if (rx_capture) begin
        rx_armed_reg <= 1'b0;
        staging_reg  <= {staging_reg[HEADER_BYTES*8-9:0], rx_data};
        byte_count   <= byte_count + 32'd1;
        if (index_reg == IW'(HEADER_BYTES - 1)) begin
          header_data  <= {staging_reg[HEADER_BYTES*8-9:0], rx_data};
          header_valid <= 1'b1;
          index_reg    <= '0;
        end else begin
          index_reg <= index_reg + 1'b1;
        end
      end
    end
  end

  // ---------------- TX path ----------------
  tx_state_t        tx_state_reg;
  logic [31:0]      nonce_reg;
  logic [CW-1:0]    cnt_reg;
  logic [N_REQ-1:0] grant;
  logic             accept;
  logic [31:0]      masked [N_REQ];
  logic [31:0]      nonce_sel;

  assign accept = (tx_state_reg == TX_IDLE) && (|nonce_req);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (nonce_req),
    .accept (accept),
    .grant  (grant)
  );

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign masked[gi] = grant[gi] ? nonce_in[32*gi +: 32] : 32'd0;
    end
  endgenerate

  always_comb begin
    nonce_sel = '0;
    for (int k = 0; k < N_REQ; k++) nonce_sel = nonce_sel | masked[k];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_reg <= TX_IDLE;
      nonce_reg    <= '0;
      cnt_reg      <= '0;
      tx_data      <= '0;
      tx_wr_en     <= 1'b0;
      nonce_ack    <= '0;
    end else begin
      tx_wr_en  <= 1'b0;
      nonce_ack <= '0;
      case (tx_state_reg)
        TX_IDLE: begin
          if (accept) begin
            nonce_reg    <= nonce_sel;
            nonce_ack    <= grant;
            cnt_reg      <= CW'(NONCE_BYTES);
            tx_state_reg <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (!tx_busy) begin
            tx_data      <= nonce_reg[31:24];
            tx_wr_en     <= 1'b1;
            tx_state_reg <= TX_WAIT_BUSY;
          end
        end
        TX_WAIT_BUSY: begin
          if (tx_busy) tx_state_reg <= TX_WAIT_DONE;
        end
        TX_WAIT_DONE: begin
          if (!tx_busy) begin
            nonce_reg    <= {nonce_reg[23:0], 8'h00};
            cnt_reg      <= cnt_reg - 1'b1;
            tx_state_reg <= (cnt_reg == CW'(1)) ? TX_IDLE : TX_SEND;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_link_ctrl.sv
// Directed bench for uart_link_ctrl with a simple UART TX busy model and
// self-releasing nonce requesters.
module tb_uart_link_ctrl;
  import uart_link_pkg::*;

  localparam int N_REQ = 2;
  localparam int HB    = 80;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_rdy = 1'b0;
  logic            rx_rdy_clr;
  logic [7:0]      tx_data;
  logic            tx_wr_en;
  logic            tx_busy;
  logic [N_REQ-1:0] nonce_req = '0;
  logic [N_REQ*32-1:0] nonce_in = '0;
  logic [N_REQ-1:0] nonce_ack;
  logic [HB*8-1:0] header_data;
  logic            header_valid;
  logic [31:0]     byte_count;

  uart_link_ctrl #(.N_REQ(N_REQ), .HEADER_BYTES(HB), .NONCE_BYTES(4)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .rx_rdy_clr(rx_rdy_clr), .tx_data(tx_data), .tx_wr_en(tx_wr_en),
    .tx_busy(tx_busy), .nonce_req(nonce_req), .nonce_in(nonce_in),
    .nonce_ack(nonce_ack), .header_data(header_data),
    .header_valid(header_valid), .byte_count(byte_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // UART transmitter model: 20 busy cycles per written byte.
  int busy_cnt = 0;
  int tx_total = 0;
  logic [7:0] tx_log [64];
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clock) begin
    if (tx_wr_en) begin
      busy_cnt <= 20;
      tx_log[tx_total % 64] <= tx_data;
      tx_total <= tx_total + 1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Requesters hold their level until enough acks arrive; event counters.
  int req_goal [N_REQ];
  int acks_seen [N_REQ];
  int ack_who [64];
  int ack_total = 0;
  int hv_total = 0;
  int clr_total = 0;
  int wr_total = 0;
  initial for (int i = 0; i < N_REQ; i++) begin req_goal[i] = 0; acks_seen[i] = 0; end
  always @(negedge clock) begin
    if (header_valid) hv_total++;
    if (rx_rdy_clr) clr_total++;
    if (tx_wr_en) wr_total++;
    for (int i = 0; i < N_REQ; i++) begin
      if (nonce_ack[i]) begin
        acks_seen[i]++;
        ack_who[ack_total % 64] = i;
        ack_total++;
      end
      nonce_req[i] = (acks_seen[i] < req_goal[i]);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int c;
    rx_data = b;
    rx_rdy  = 1'b1;
    c = 0;
    do begin @(negedge clock); c++; end while (!rx_rdy_clr && c < 10);
    if (!rx_rdy_clr) check("rx_clr_timeout", 0, 1);
    rx_rdy = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Wait until the given number of tx bytes went out and the line is idle.
  task automatic wait_tx(input int target, input string tag);
    int c;
    c = 0;
    while (!(tx_total >= target && !tx_busy) && c < 3000) begin @(negedge clock); c++; end
    check(tag, (tx_total >= target) ? 1 : 0, 1);
    repeat (3) @(negedge clock);
  endtask

  logic [HB*8-1:0] exp_hdr;
  int base_tx, base_ack, base_hv, base_clr, base_wr;

  initial begin
    @(negedge clock);
    do_reset();
    // reset state
    check("rst_rx_rdy_clr", rx_rdy_clr, 0);
    check("rst_tx_wr_en", tx_wr_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_nonce_ack", nonce_ack, 0);
    check("rst_header_valid", header_valid, 0);
    check("rst_header_data", header_data, 0);
    check("rst_byte_count", byte_count, 0);

    // first full header, bytes 0x01..0x50
    for (int k = 1; k <= 80; k++) send_byte(8'(k));
    for (int j = 0; j < 80; j++) exp_hdr[8*(79-j) +: 8] = 8'(j + 1);
    check("hdr1_pulses", hv_total, 1);
    check("hdr1_top", header_data[639:632], 8'h01);
    check("hdr1_bottom", header_data[7:0], 8'h50);
    check("hdr1_full", header_data, exp_hdr);
    check("hdr1_byte_count", byte_count, 80);

    // five more bytes: no new header, data unchanged
    for (int k = 81; k <= 85; k++) send_byte(8'(k));
    check("partial_pulses", hv_total, 1);
    check("partial_hdr_stable", header_data, exp_hdr);
    check("partial_byte_count", byte_count, 85);
    // index was 5: 74 more bytes do not complete, the 75th does
    for (int k = 86; k <= 159; k++) send_byte(8'(k));
    check("hdr2_not_early", hv_total, 1);
    send_byte(8'd160);
    for (int j = 0; j < 80; j++) exp_hdr[8*(79-j) +: 8] = 8'(j + 81);
    check("hdr2_pulses", hv_total, 2);
    check("hdr2_full", header_data, exp_hdr);

    // rx_rdy held 3 cycles with no clear response
    base_clr = clr_total;
    rx_data = 8'hEE; rx_rdy = 1'b1;
    repeat (3) @(negedge clock);
    rx_rdy = 1'b0;
    repeat (2) @(negedge clock);
    check("stuck_rdy_clr_cycles", clr_total - base_clr, 1);
    check("stuck_rdy_byte_count", byte_count, 161);

    // core 0 alone, nonce 0x42A14694
    base_tx = tx_total; base_ack = ack_total; base_wr = wr_total;
    nonce_in[31:0] = 32'h42A14694;
    req_goal[0] = acks_seen[0] + 1;
    wait_tx(base_tx + 4, "n0_timeout");
    check("n0_ack_count", ack_total - base_ack, 1);
    check("n0_ack_core", ack_who[base_ack % 64], 0);
    check("n0_b0", tx_log[base_tx % 64], 8'h42);
    check("n0_b1", tx_log[(base_tx + 1) % 64], 8'hA1);
    check("n0_b2", tx_log[(base_tx + 2) % 64], 8'h46);
    check("n0_b3", tx_log[(base_tx + 3) % 64], 8'h94);
    check("n0_wr_pulses", wr_total - base_wr, 4);
    check("n0_idle", dut.tx_state_reg, TX_IDLE);

    // simultaneous requests from a fresh pointer
    do_reset();
    base_tx = tx_total; base_ack = ack_total;
    nonce_in = {32'h22222222, 32'h11111111};
    req_goal[0] = acks_seen[0] + 1;
    req_goal[1] = acks_seen[1] + 1;
    wait_tx(base_tx + 8, "rr1_timeout");
    check("rr1_first", ack_who[base_ack % 64], 0);
    check("rr1_second", ack_who[(base_ack + 1) % 64], 1);
    check("rr1_byte0", tx_log[base_tx % 64], 8'h11);
    check("rr1_byte4", tx_log[(base_tx + 4) % 64], 8'h22);

    base_tx = tx_total; base_ack = ack_total;
    req_goal[0] = acks_seen[0] + 2;
    req_goal[1] = acks_seen[1] + 2;
    wait_tx(base_tx + 16, "rr2_timeout");
    for (int i = 0; i < 4; i++)
      check($sformatf("rr2_order%0d", i), ack_who[(base_ack + i) % 64], i % 2);

    // lone requester served back to back
    base_tx = tx_total; base_ack = ack_total;
    req_goal[1] = acks_seen[1] + 2;
    wait_tx(base_tx + 8, "lone_timeout");
    check("lone_ack_count", ack_total - base_ack, 2);
    check("lone_second", ack_who[(base_ack + 1) % 64], 1);

    // reset after the second tx byte aborts the nonce
    base_tx = tx_total; base_ack = ack_total;
    nonce_in[31:0] = 32'hA1B2C3D4;
    req_goal[0] = acks_seen[0] + 1;
    for (int c = 0; c < 2000 && tx_total < base_tx + 2; c++) @(negedge clock);
    check("abort_reach", (tx_total >= base_tx + 2) ? 1 : 0, 1);
    base_wr = wr_total;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    check("abort_no_wr", wr_total - base_wr, 0);
    check("abort_idle", dut.tx_state_reg, TX_IDLE);
    base_tx = tx_total;
    nonce_in[31:0] = 32'h55667788;
    req_goal[0] = acks_seen[0] + 1;
    wait_tx(base_tx + 4, "post_abort_timeout");
    check("post_abort_b0", tx_log[base_tx % 64], 8'h55);
    check("post_abort_b3", tx_log[(base_tx + 3) % 64], 8'h88);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_link_ctrl.md
UART_LINK_CTRL -- requirements
Module: uart_link_ctrl

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of hashing-core nonce requesters (1..8).
REQ-002 SHALL have parameter HEADER_BYTES, default 80, bytes per block header.
REQ-003 SHALL have parameter NONCE_BYTES, default 4, bytes per transmitted nonce.
REQ-004 SHALL have port clock  in  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port rx_data  in  8  received byte from the UART (dout).
REQ-007 SHALL have port rx_rdy  in  1  UART byte-ready flag, held high until cleared.
REQ-008 SHALL have port rx_rdy_clr  out  1  clear pulse to the UART ready flag.
REQ-009 SHALL have port tx_data  out  8  byte to the UART transmitter (din).
REQ-010 SHALL have port tx_wr_en  out  1  one-cycle transmit strobe.
REQ-011 SHALL have port tx_busy  in  1  UART transmitter busy.
REQ-012 SHALL have port nonce_req  in  N_REQ  per-core request, level, held until acked.
REQ-013 SHALL have port nonce_in  in  N_REQ*32  per-core nonce, core i at bits [32i+31:32i].
REQ-014 SHALL have port nonce_ack  out  N_REQ  one-cycle capture acknowledge per core.
REQ-015 SHALL have port header_data  out  HEADER_BYTES*8  last completed header.
REQ-016 SHALL have port header_valid  out  1  one-cycle pulse, new header available.
REQ-017 SHALL have port byte_count  out  32  total received bytes, wraps at 2^32.

Function
REQ-018 SHALL capture rx_data when rx_rdy=1 and rx_rdy_clr=0, then drive rx_rdy_clr=1 for exactly the next cycle.
REQ-019 SHALL shift each captured byte into a staging register from the LSB side, so the first byte of a header ends in the top byte of header_data.
REQ-020 SHALL keep a byte index 0..HEADER_BYTES-1; on capture at index HEADER_BYTES-1 SHALL copy staging to header_data, pulse header_valid the following cycle, and wrap the index to 0.
REQ-021 SHALL hold header_data stable between completions; partial headers SHALL never appear on it.
REQ-022 SHALL increment byte_count by one per captured byte, wrapping 0xFFFFFFFF -> 0.
REQ-023 SHALL run TX FSM states IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-024 IDLE: if any nonce_req bit is set, SHALL grant round-robin starting after the last granted core, latch that core's nonce, pulse its nonce_ack the same cycle, load byte counter with NONCE_BYTES, go SEND.
REQ-025 SEND: when tx_busy=0, SHALL drive tx_data=nonce[31:24], tx_wr_en=1 for one cycle, go WAIT_BUSY; else stay.
REQ-026 WAIT_BUSY: on tx_busy=1 SHALL go WAIT_DONE.
REQ-027 WAIT_DONE: on tx_busy=0 SHALL shift nonce left 8 and decrement the counter; counter reaching 0 -> IDLE, else -> SEND.
REQ-028 SHALL transmit nonce bytes MSB first with no gaps beyond UART handshake latency.
REQ-029 Requests arriving while not IDLE SHALL wait; no nonce_ack SHALL be issued outside IDLE.
REQ-030 Simultaneous requests SHALL be served one per transaction in round-robin order; a lone requester SHALL be served back to back.
REQ-031 RX and TX paths SHALL operate independently and concurrently.

Reset
REQ-032 On reset SHALL force: rx_rdy_clr=0, tx_wr_en=0, tx_data=0, nonce_ack=0, header_valid=0, header_data=0, byte_count=0, byte index=0, FSM=IDLE, round-robin pointer so core 0 has highest priority.
REQ-033 Reset mid-header SHALL discard partial bytes; reset mid-nonce SHALL abort without resuming, and the acked nonce SHALL be lost.

Structure
REQ-034 Package uart_link_pkg SHALL hold the default HEADER_BYTES, NONCE_BYTES and the TX state encoding.
REQ-035 Round-robin grant logic SHALL be one sub-module, rr_arbiter (N_REQ requests, one-hot grant, pointer update on accept).

Verification
REQ-036 Feed 80 bytes 0x01..0x50 -> one header_valid pulse; header_data top byte 0x01, bottom byte 0x50; byte_count=80.
REQ-037 Feed 85 bytes -> one header_valid; byte index=5; header_data unchanged after byte 80; byte_count=85.
REQ-038 Core 0 requests with nonce 0x42A14694, 20-cycle busy model -> ack pulse, tx bytes 0x42,0xA1,0x46,0x94 in order, four tx_wr_en pulses, FSM back in IDLE.
REQ-039 Cores 0 and 1 request together (0x11111111, 0x22222222) -> core 0 served first, then core 1; repeat with both held -> order 0,1,0,1.
REQ-040 Reset asserted after the second tx byte -> tx_wr_en stays 0, FSM IDLE, next request starts at byte 0 of the new nonce.
REQ-041 rx_rdy held high 3 cycles without clear response -> exactly one byte captured, rx_rdy_clr one cycle.
